// File: rtl/uart_peripheral_if.sv
// CPU peripheral bus seen by uart_peripheral: address, read/write strobes and data.
interface uart_peripheral_if;
  // Single-cycle bus with no ready: a strobe (rd_en or wr_en) held for one clock
  // is one complete access; rdata is valid in that same cycle.
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output rd_en, output wr_en, output wdata, input rdata);
  modport slave  (input addr, input rd_en, input wr_en, input wdata, output rdata);
endinterface

// File: rtl/uart_peripheral.sv
// Memory-mapped UART (TXD/RXD/CON registers) with independent TX and RX bit engines.
// Optional macro UART_TX_BUF_EN adds a one-byte TX holding register for back-to-back frames.
module uart_peripheral #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              reset,
  uart_peripheral_if.slave  bus,
  input  logic              rx,
  output logic              tx,
  output logic              irq,
  output logic [1:0]        tx_fsm_state,
  output logic [1:0]        rx_fsm_state
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] TXD_ADDR = BASE_ADDR + 32'h18;
  localparam logic [31:0] RXD_ADDR = BASE_ADDR + 32'h1C;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'h20;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [7:0]    txd_q, txd_d, rxd_q;
  logic [1:0]    irq_en_q;
  logic          tx_q, tx_line_d, tx_done_q, tx_done_set, tx_busy, tx_bit_end;
  logic          rx_ready_q, rx_set, rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;
  logic          sel_txd, sel_rxd, sel_con, txd_wr, con_wr, con_rd;
  logic          unused_wdata;
`ifdef UART_TX_BUF_EN
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
`endif

  assign sel_txd      = (bus.addr == TXD_ADDR);
  assign sel_rxd      = (bus.addr == RXD_ADDR);
  assign sel_con      = (bus.addr == CON_ADDR);
  assign txd_wr       = bus.wr_en & sel_txd;
  assign con_wr       = bus.wr_en & sel_con;
  assign con_rd       = bus.rd_en & sel_con;
  assign unused_wdata = ^bus.wdata[31:8];

`ifdef UART_TX_BUF_EN
  assign tx_busy = (tx_state_q != ST_IDLE) | hold_full_q;
`else
  assign tx_busy = (tx_state_q != ST_IDLE);
`endif

  assign tx           = tx_q;
  assign irq          = (irq_en_q[0] & tx_done_q) | (irq_en_q[1] & rx_ready_q);
  assign tx_fsm_state = tx_state_q;
  assign rx_fsm_state = rx_state_q;
  assign tx_bit_end   = (tx_cnt_q == BIT_LAST);
  assign rx_fall      = rx_prev_q & ~rx_s2_q;

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.rd_en) begin
      if (sel_txd)      bus.rdata = {24'h0, txd_q};
      else if (sel_rxd) bus.rdata = {24'h0, rxd_q};
      else if (sel_con) bus.rdata = {27'h0, tx_busy, rx_ready_q, tx_done_q, irq_en_q};
    end
  end

  // TX engine; the line value is computed from next-state so tx itself is a flop.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    txd_d       = txd_q;
    tx_done_set = 1'b0;
`ifdef UART_TX_BUF_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (tx_state_q)
      ST_IDLE: begin
        if (txd_wr) begin
          tx_state_d = ST_START;
          tx_cnt_d   = '0;
          tx_shift_d = bus.wdata[7:0];
          txd_d      = bus.wdata[7:0];
        end
      end
      ST_START: begin
        if (tx_bit_end) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
`ifdef UART_TX_BUF_EN
          if (hold_full_q) begin
            tx_state_d  = ST_START;
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
          end else if (txd_wr) begin
            tx_state_d = ST_START;
            tx_shift_d = bus.wdata[7:0];
            txd_d      = bus.wdata[7:0];
          end else begin
            tx_state_d  = ST_IDLE;
            tx_done_set = 1'b1;
          end
`else
          tx_state_d  = ST_IDLE;
          tx_done_set = 1'b1;
`endif
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
`ifdef UART_TX_BUF_EN
    // A frame that is about to end picks the write up directly above instead.
    if (txd_wr && (tx_state_q != ST_IDLE) && !hold_full_q &&
        !((tx_state_q == ST_STOP) && tx_bit_end)) begin
      hold_d      = bus.wdata[7:0];
      hold_full_d = 1'b1;
      txd_d       = bus.wdata[7:0];
    end
`endif
    tx_line_d = 1'b1;
    if (tx_state_d == ST_START)     tx_line_d = 1'b0;
    else if (tx_state_d == ST_DATA) tx_line_d = tx_shift_d[0];
  end

  // RX engine: all sampling uses the synchronised line rx_s2_q.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_set     = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          rx_set     = rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      tx_q        <= 1'b1;
      txd_q       <= 8'h00;
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      rxd_q       <= 8'h00;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      irq_en_q    <= 2'b00;
      tx_done_q   <= 1'b0;
      rx_ready_q  <= 1'b0;
`ifdef UART_TX_BUF_EN
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
`endif
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_line_d;
      txd_q       <= txd_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      if (rx_set) rxd_q <= rx_shift_q;
      if (con_wr) irq_en_q <= bus.wdata[1:0];
      // A set event in the same cycle as a CON read keeps the flag.
      tx_done_q   <= tx_done_set | (tx_done_q & ~con_rd);
      rx_ready_q  <= rx_set | (rx_ready_q & ~con_rd);
`ifdef UART_TX_BUF_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_peripheral.sv
// Directed bench for uart_peripheral: register table, TX/RX frames, glitch, framing,
// read/set collision, loopback and mid-frame reset, all with CLKS_PER_BIT=16.
`timescale 1ns/1ps
module tb_uart_peripheral;
  localparam int          CPB   = 16;
  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] A_TXD = BASE + 32'h18;
  localparam logic [31:0] A_RXD = BASE + 32'h1C;
  localparam logic [31:0] A_CON = BASE + 32'h20;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loopback = 1'b0;
  logic       rx_line, tx, irq;
  logic [1:0] tx_fsm_state, rx_fsm_state;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rx = 8'h00;
  vec_t       vecs[10];

  uart_peripheral_if bus ();
  assign rx_line = loopback ? tx : rx_drv;

  uart_peripheral #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus), .rx(rx_line), .tx(tx), .irq(irq),
    .tx_fsm_state(tx_fsm_state), .rx_fsm_state(rx_fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a; bus.rd_en = 1'b1;
    #1 d = bus.rdata;
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.addr = 32'h0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive_bits(input logic [7:0] b);
    rx_drv = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_stop(input logic s);
    rx_drv = s;
    repeat (CPB) @(posedge clk);
    #1 rx_drv = 1'b1;
  endtask

  // scoreboard: received bytes come off exp_q in order
  task automatic check_rxd(input string name);
    logic [31:0] d;
    logic [7:0]  e;
    bus_read(A_RXD, d);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got %h expected <empty scoreboard>", name, d);
    end else begin
      e = exp_q.pop_front();
      check(name, d, {24'h0, e});
      last_rx = e;
    end
  endtask

  initial begin
    int          e0;
    int          hits;
    logic [9:0]  frame;
    logic [31:0] d;

    vecs[0] = '{1'b0, 1'b1, A_CON, 32'h0, 32'h0, "rst_con"};
    vecs[1] = '{1'b0, 1'b1, A_RXD, 32'h0, 32'h0, "rst_rxd"};
    vecs[2] = '{1'b0, 1'b1, A_TXD, 32'h0, 32'h0, "rst_txd"};
    vecs[3] = '{1'b1, 1'b0, A_CON, 32'hFFFF_FFFF, 32'h0, "wr_con_all"};
    vecs[4] = '{1'b0, 1'b1, A_CON, 32'h0, 32'h3, "con_rw_bits"};
    vecs[5] = '{1'b0, 1'b0, A_CON, 32'h0, 32'h0, "no_rd_strobe"};
    vecs[6] = '{1'b0, 1'b1, BASE + 32'h19, 32'h0, 32'h0, "misaligned"};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0, 32'h0, "wrong_base"};
    vecs[8] = '{1'b1, 1'b0, A_CON, 32'h0, 32'h0, "wr_con_zero"};
    vecs[9] = '{1'b0, 1'b1, A_CON, 32'h0, 32'h0, "con_cleared"};

    bus.addr = 32'h0; bus.wdata = 32'h0; bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rx_fsm", 32'(rx_fsm_state), 32'd0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].a, vecs[i].d);
      end else begin
        bus.addr = vecs[i].a; bus.rd_en = vecs[i].rd;
        #1 check(vecs[i].name, bus.rdata, vecs[i].exp);
        check({vecs[i].name, "_irq"}, 32'(irq), 32'd0);
        @(posedge clk); #1;
        bus.rd_en = 1'b0; bus.addr = 32'h0;
      end
    end

    // TX frame 0x55
    frame = {1'b1, 8'h55, 1'b0};
    bus_write(A_TXD, 32'h55);
    e0 = cyc;
    for (int k = 0; k < 10; k++) begin
      wait_to(e0 + CPB * k + CPB / 2);
      check($sformatf("tx55_bit%0d", k), 32'(tx), 32'(frame[k]));
      if (k == 4) read_check("con_busy", A_CON, 32'h10);
    end
    wait_to(e0 + 10 * CPB + 8);
    check("tx_idle_after", 32'(tx), 32'd1);
    bus_write(A_CON, 32'h1);
    check("tx_irq_on", 32'(irq), 32'd1);
    bus_write(A_CON, 32'h0);
    check("tx_irq_off", 32'(irq), 32'd0);
    read_check("con_tx_done", A_CON, 32'h04);
    read_check("con_done_clr", A_CON, 32'h00);

    // RX frame 0x3C with rx interrupt enabled
    bus_write(A_CON, 32'h2);
    exp_q.push_back(8'h3C);
    drive_bits(8'h3C);
    check("rx_irq_pre_stop", 32'(irq), 32'd0);
    drive_stop(1'b1);
    check("rx_irq_set", 32'(irq), 32'd1);
    read_check("con_rx_ready", A_CON, 32'h0A);
    check("rx_irq_fall", 32'(irq), 32'd0);
    check_rxd("rxd_3c");
    read_check("con_ready_clr", A_CON, 32'h02);

    // 4-cycle glitch, then a framing error: neither changes RXD or rx_ready
    rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    #1 read_check("glitch_con", A_CON, 32'h02);
    read_check("glitch_rxd", A_RXD, {24'h0, last_rx});
    drive_bits(8'hA5);
    drive_stop(1'b0);
    repeat (40) @(posedge clk);
    #1 read_check("frame_err_con", A_CON, 32'h02);
    read_check("frame_err_rxd", A_RXD, {24'h0, last_rx});

    // CON read held through the rx_ready set edge: flag must survive exactly one cycle
    exp_q.push_back(8'h5A);
    drive_bits(8'h5A);
    rx_drv = 1'b1;
    bus.addr = A_CON; bus.rd_en = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rdata[3]) hits++;
    end
    bus.rd_en = 1'b0; bus.addr = 32'h0;
    check("set_wins_over_clear", 32'(hits), 32'd1);
    check_rxd("rxd_5a");
    read_check("con_after_collide", A_CON, 32'h02);

    // loopback, second write while busy
    bus_write(A_CON, 32'h3);
    loopback = 1'b1;
    bus_write(A_TXD, 32'h18);
    e0 = cyc;
    bus_write(A_TXD, 32'h77);
    exp_q.push_back(8'h18);
    wait_to(e0 + 180);
    check("loop_irq", 32'(irq), 32'd1);
`ifdef UART_TX_BUF_EN
    read_check("loop_con1", A_CON, 32'h1B);
`else
    read_check("loop_con1", A_CON, 32'h0F);
`endif
    check("loop_irq_clr", 32'(irq), 32'd0);
    check_rxd("loop_rxd1");
`ifdef UART_TX_BUF_EN
    read_check("loop_txd", A_TXD, 32'h77);
    exp_q.push_back(8'h77);
`else
    read_check("loop_txd", A_TXD, 32'h18);
`endif
    wait_to(e0 + 340);
`ifdef UART_TX_BUF_EN
    read_check("loop_con2", A_CON, 32'h0F);
    check_rxd("loop_rxd2");
`else
    read_check("loop_con2", A_CON, 32'h03);
    read_check("loop_rxd2", A_RXD, {24'h0, last_rx});
`endif
    loopback = 1'b0;
    bus_write(A_CON, 32'h3);

    // reset during data bit 4 of 0x0F
    bus_write(A_TXD, 32'h0F);
    e0 = cyc;
    wait_to(e0 + 5 * CPB + CPB / 2);
    check("pre_reset_tx", 32'(tx), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("reset_tx_high", 32'(tx), 32'd1);
    check("reset_tx_fsm", 32'(tx_fsm_state), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    read_check("reset_con", A_CON, 32'h0);
    repeat (200) @(posedge clk);
    #1 read_check("reset_no_done", A_CON, 32'h0);
    check("reset_tx_idle", 32'(tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_peripheral.md
Name: uart_peripheral

Overview:
Memory-mapped UART responder on the CPU peripheral bus at base 0x40000000. It decodes the UART_TXD, UART_RXD and UART_CON word registers. It serialises bytes written by the CPU onto tx, deserialises frames arriving on rx, and raises an interrupt request. Software polls UART_CON bit 3 for received data, reads UART_RXD, and writes results to UART_TXD.

Parameters:
CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud); must be >= 4.
BASE_ADDR, 32'h40000000, peripheral base address; register offsets are fixed.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
addr  in  32  byte address of current bus access
rd_en  in  1  bus read strobe
wr_en  in  1  bus write strobe
wdata  in  32  write data
rdata  out  32  read data, combinational
rx  in  1  serial input, asynchronous, idle high
tx  out  1  serial output, idle high
irq  out  1  interrupt request, level

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on port reset. All state updates on the rising edge of clk.
- Register map (offsets from BASE_ADDR, word-aligned; only exact matches decode):
  - 0x18 UART_TXD: write of wdata[7:0] requests transmit. Read returns the last written byte in [7:0].
  - 0x1C UART_RXD: read returns the last received byte in [7:0], zero-extended.
  - 0x20 UART_CON:
    - bit0 tx_irq_en, R/W
    - bit1 rx_irq_en, R/W
    - bit2 tx_done, RO, clear-on-read
    - bit3 rx_ready, RO, clear-on-read
    - bit4 tx_busy, RO
    - writes affect bits [1:0] only; other bits read 0.
- rdata: decoded register value when rd_en=1 and addr matches; otherwise 32'h0. Zero-latency combinational read (single-cycle CPU).
- Clear-on-read: at the edge where rd_en=1 and addr=CON, tx_done and rx_ready clear. If a set event occurs in the same cycle, set wins and the flag stays 1.
- Reset values: tx=1, irq=0, CON=0, TXD=0, RXD=0, both FSMs IDLE, all counters 0.
- irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_ready), registered from the flags with no extra delay.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - A write to TXD in IDLE enters START on the next edge; tx goes low the cycle after the write.
  - Each state lasts CLKS_PER_BIT cycles. DATA sends 8 bits LSB first; STOP drives 1.
  - At the end of STOP: set tx_done, return to IDLE.
  - tx_busy = (state != IDLE).
  - A write to TXD while busy is ignored: TXD value and frame are unchanged (see optional feature).
- RX path: 2-flop synchroniser on rx. FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronised falling edge enters START.
  - START: after CLKS_PER_BIT/2 cycles, sample. If high, treat as a glitch and return to IDLE with no flag. If low, go to DATA.
  - DATA: sample 8 bits at mid-bit (every CLKS_PER_BIT), shift in LSB first.
  - STOP: sample at mid-bit. If 1, load RXD and set rx_ready. If 0 (framing error), discard the byte, leave RXD and rx_ready unchanged. Then IDLE.
- Overrun: a new valid byte arriving while rx_ready=1 overwrites RXD; rx_ready stays 1.
- TX and RX operate independently and concurrently. Full-duplex loopback (tx tied to rx) must work.
- Reset mid-frame: both FSMs abort immediately, tx returns high the next cycle, and no flag is set.

Optional Feature:
UART_TX_BUF_EN:
- Defined: adds a one-byte TX holding register. A TXD write while busy is latched if the holding register is empty, and transmitted back-to-back after the current STOP with no idle bit. A further write while the holding register is full is dropped. tx_busy stays 1 while a frame is active or the holding register is full. tx_done sets only when the FSM goes idle with the holding register empty.
- Undefined: writes while busy are ignored, as in Behaviour.

Test Plan:
- Reset, then read CON/RXD/TXD -> all read 32'h0; tx=1; irq=0. (All scenarios use CLKS_PER_BIT=16.)
- Write 0x55 to 0x40000018 -> tx low for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high. CON reads 0x10 during the frame and 0x04 after it. A second CON read returns 0x00.
- Drive frame 0x3C on rx; poll CON -> bit3=1; RXD read = 0x0000003C; next CON read bit3=0. Set CON=0x2 before the frame -> irq rises when the stop bit is sampled and falls after the CON read.
- rx low pulse of 4 cycles -> no flag, RXD unchanged. Frame 0xA5 with stop bit 0 -> no rx_ready, RXD unchanged.
- Loopback tx->rx: write 0x18 (24) -> RXD=0x18 and rx_ready set after ~10 bit times. Write 0x77 while busy -> ignored without UART_TX_BUF_EN; sent back-to-back with UART_TX_BUF_EN.
- Assert reset mid-TX at bit 4 -> tx=1 next cycle, CON=0. A read of CON in the same cycle rx_ready sets -> rx_ready remains 1.
